// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-port, fixed-latency unified memory between the
// instruction-fetch requester (IF) and the data requester (MEM). Requests
// are level-held. One access is granted at a time, and it drives the memory
// port for exactly LAT cycles. The requester then gets a one-cycle ready
// pulse with registered read data. When both requesters contend, the grant
// alternates between them.
//
// Parameters:
//   AW   word-address width
//   LAT  memory access cycles per transaction (1..7)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   if_req    fetch request, held until if_ready
//   if_addr   fetch word address
//   if_rdata  fetched word, valid with if_ready, held until next fetch completes
//   if_ready  one-cycle fetch-complete pulse
//   d_req     data request, held until d_ready
//   d_we      1 = write, 0 = read
//   d_addr    data word address
//   d_wdata   write data
//   d_rdata   read data, valid with d_ready, held until next data read completes
//   d_ready   one-cycle data-complete pulse (reads and writes)
//   m_en      memory enable, high for LAT cycles per access
//   m_we      memory write enable (same cycles as m_en, writes only)
//   m_addr    latched access address
//   m_wdata   latched write data
//   m_rdata   memory read data, valid on the last m_en cycle
//   busy      high whenever the sequencer is not idle
//
// Every output comes straight from a register.
module mem_arbiter #(
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_D  = 2'd2
  } state_t;

  // The counter is loaded with LAT-1 on the grant edge. It reaches 0 in the
  // last m_en cycle.
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic            last_reg, last_next;       // 0 = fetch last granted, 1 = data
  logic            m_en_reg, m_en_next;
  logic            m_we_reg, m_we_next;       // doubles as the latched we bit
  logic [AW-1:0]   m_addr_reg, m_addr_next;
  logic [31:0]     m_wdata_reg, m_wdata_next;
  logic [31:0]     if_rdata_reg, if_rdata_next;
  logic [31:0]     d_rdata_reg, d_rdata_next;
  logic            if_ready_reg, if_ready_next;
  logic            d_ready_reg, d_ready_next;
  logic            busy_reg, busy_next;

  // Eligibility is masked by the ready pulse. In that cycle the requester is
  // still dropping its request, and it must not be granted a second access.
  logic            if_elig, d_elig;
  logic            grant_if, grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      last_reg     <= 1'b0;
      m_en_reg     <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= 32'd0;
      if_rdata_reg <= 32'd0;
      d_rdata_reg  <= 32'd0;
      if_ready_reg <= 1'b0;
      d_ready_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_reg     <= last_next;
      m_en_reg     <= m_en_next;
      m_we_reg     <= m_we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
      if_ready_reg <= if_ready_next;
      d_ready_reg  <= d_ready_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_next     = last_reg;
    m_en_next     = m_en_reg;
    m_we_next     = m_we_reg;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    if_ready_next = 1'b0;
    d_ready_next  = 1'b0;
    busy_next     = busy_reg;

    if_elig  = if_req & ~if_ready_reg;
    d_elig   = d_req & ~d_ready_reg;
    // Data wins unless fetch is also eligible and data was granted last.
    grant_d  = d_elig & (~if_elig | ~last_reg);
    grant_if = if_elig & ~grant_d;

    unique case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next   = ACC_D;
          cnt_next     = CNT_INIT;
          last_next    = 1'b1;
          m_en_next    = 1'b1;
          m_we_next    = d_we;
          m_addr_next  = d_addr;
          m_wdata_next = d_wdata;
          busy_next    = 1'b1;
        end else if (grant_if) begin
          state_next   = ACC_IF;
          cnt_next     = CNT_INIT;
          last_next    = 1'b0;
          m_en_next    = 1'b1;
          m_we_next    = 1'b0;
          m_addr_next  = if_addr;
          busy_next    = 1'b1;
        end
      end

      ACC_IF: begin
        if (cnt_reg == 3'd0) begin
          if_rdata_next = m_rdata;
          if_ready_next = 1'b1;
          state_next    = IDLE;
          m_en_next     = 1'b0;
          busy_next     = 1'b0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end

      ACC_D: begin
        if (cnt_reg == 3'd0) begin
          // Writes complete with a ready pulse and leave d_rdata untouched.
          if (!m_we_reg) begin
            d_rdata_next = m_rdata;
          end
          d_ready_next = 1'b1;
          state_next   = IDLE;
          m_en_next    = 1'b0;
          m_we_next    = 1'b0;
          busy_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end

      default: begin
        state_next = IDLE;
        m_en_next  = 1'b0;
        m_we_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign if_rdata = if_rdata_reg;
  assign if_ready = if_ready_reg;
  assign d_rdata  = d_rdata_reg;
  assign d_ready  = d_ready_reg;
  assign m_en     = m_en_reg;
  assign m_we     = m_we_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with AW = 10 and LAT = 2.
// The memory model returns 0x2002_0001 + address on m_rdata.
module tb_mem_arbiter;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          busy;

  int checks;
  int failures;

  mem_arbiter #(.AW(AW), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  assign m_rdata = 32'h2002_0001 + {22'd0, m_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic we,
                            input logic [AW-1:0] addr, input logic ifr,
                            input logic dr, input logic bsy);
    check({tag, ".m_en"}, {31'd0, m_en}, {31'd0, en});
    check({tag, ".m_we"}, {31'd0, m_we}, {31'd0, we});
    if (en) check({tag, ".m_addr"}, {22'd0, m_addr}, {22'd0, addr});
    check({tag, ".if_ready"}, {31'd0, if_ready}, {31'd0, ifr});
    check({tag, ".d_ready"}, {31'd0, d_ready}, {31'd0, dr});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
    $display("cyc %s en=%b we=%b addr=%h ifr=%b dr=%b busy=%b", tag, m_en, m_we, m_addr,
             if_ready, d_ready, busy);
  endtask

  // Advance to just after the next rising edge: outputs are settled and
  // inputs changed here take effect at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    if_req   = 1'b1;
    if_addr  = 10'h004;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = 10'h010;
    d_wdata  = 32'd0;

    // Reset held 2 cycles with both requests high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check_outs("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("rst.if_rdata", if_rdata, 32'd0);
      check("rst.d_rdata", d_rdata, 32'd0);
      check("rst.m_addr", {22'd0, m_addr}, 32'd0);
      check("rst.m_wdata", m_wdata, 32'd0);
    end
    rst = 1'b1;                       // cycle 0
    tick(); check_outs("first1", 1'b1, 1'b0, 10'h010, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("first2", 1'b1, 1'b0, 10'h010, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("first3", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("first3.d_rdata", d_rdata, 32'h2002_0011);
    if_req = 1'b0;
    d_req  = 1'b0;
    tick(); check_outs("first4", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Single fetch.
    if_req  = 1'b1;
    if_addr = 10'h004;
    tick(); check_outs("fetch1", 1'b1, 1'b0, 10'h004, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("fetch2", 1'b1, 1'b0, 10'h004, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("fetch3", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("fetch3.if_rdata", if_rdata, 32'h2002_0005);
    if_req = 1'b0;
    tick(); check_outs("fetch4", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("fetch4.if_rdata", if_rdata, 32'h2002_0005);

    // Data write.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 10'h010;
    d_wdata = 32'hDEAD_BEEF;
    tick(); check_outs("wr1", 1'b1, 1'b1, 10'h010, 1'b0, 1'b0, 1'b1);
    check("wr1.m_wdata", m_wdata, 32'hDEAD_BEEF);
    tick(); check_outs("wr2", 1'b1, 1'b1, 10'h010, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("wr3", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("wr3.d_rdata", d_rdata, 32'h2002_0011);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick(); check_outs("wr4", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("wr4.m_wdata", m_wdata, 32'hDEAD_BEEF);

    // Contention from a fresh reset: data first, then strict alternation.
    rst = 1'b0;
    tick();
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 10'h004;
    d_req   = 1'b1;
    d_addr  = 10'h020;
    for (int k = 1; k <= 12; k++) begin
      int  slot;
      int  phase;
      logic is_d;
      slot  = (k - 1) / 3;
      phase = (k - 1) % 3;
      is_d  = (slot % 2) == 0;
      tick();
      if (phase < 2) begin
        check_outs($sformatf("cont%0d", k), 1'b1, 1'b0, is_d ? 10'h020 : 10'h004,
                   1'b0, 1'b0, 1'b1);
      end else begin
        check_outs($sformatf("cont%0d", k), 1'b0, 1'b0, '0, !is_d, is_d, 1'b0);
        if (is_d) check($sformatf("cont%0d.d_rdata", k), d_rdata, 32'h2002_0021);
        else      check($sformatf("cont%0d.if_rdata", k), if_rdata, 32'h2002_0005);
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick(); check_outs("cont13", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Late data arrival during a fetch.
    if_req  = 1'b1;
    if_addr = 10'h004;
    tick(); check_outs("late1", 1'b1, 1'b0, 10'h004, 1'b0, 1'b0, 1'b1);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 10'h030;
    tick(); check_outs("late2", 1'b1, 1'b0, 10'h004, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("late3", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    if_req = 1'b0;
    tick(); check_outs("late4", 1'b1, 1'b0, 10'h030, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("late5", 1'b1, 1'b0, 10'h030, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("late6", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("late6.d_rdata", d_rdata, 32'h2002_0031);
    d_req = 1'b0;
    tick(); check_outs("late7", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a fetch read, request kept high.
    if_req  = 1'b1;
    if_addr = 10'h008;
    tick(); check_outs("mid1", 1'b1, 1'b0, 10'h008, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("mid2", 1'b1, 1'b0, 10'h008, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick(); check_outs("mid3", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("mid3.if_rdata", if_rdata, 32'd0);
    rst = 1'b1;
    tick(); check_outs("mid4", 1'b1, 1'b0, 10'h008, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("mid5", 1'b1, 1'b0, 10'h008, 1'b0, 1'b0, 1'b1);
    tick(); check_outs("mid6", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("mid6.if_rdata", if_rdata, 32'h2002_0009);
    if_req = 1'b0;
    tick(); check_outs("mid7", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline. It accepts level-held requests, grants one at a time, drives the memory port for exactly LAT cycles per access, and returns a one-cycle ready pulse with registered read data. The pipeline uses the ready pulses as its stall release for IF and MEM.

## Interface
- AW, 10: word-address width (4K-byte memory).
- LAT, 2: memory access cycles per transaction, legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  AW  fetch word address; stable while if_req high.
- if_rdata  out  32  fetched word; valid with if_ready, held until the next fetch completes.
- if_ready  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = write, 0 = read; stable while d_req high.
- d_addr  in  AW  data word address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data; valid with d_ready, held until the next data read completes.
- d_ready  out  1  one-cycle pulse: data access complete (reads and writes).
- m_en  out  1  memory enable, high for exactly LAT cycles per access.
- m_we  out  1  memory write enable, high only during write accesses (same cycles as m_en).
- m_addr  out  AW  latched access address.
- m_wdata  out  32  latched write data.
- m_rdata  in  32  memory read data, valid on the last m_en cycle.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACC_IF, ACC_D. Counter cnt, 3 bits. Flag last, 0 = fetch last granted, 1 = data last granted.
- IDLE: eligible requests are if_req masked by if_ready, and d_req masked by d_ready. This masking prevents a re-grant in the cycle the requester is dropping its request.
  - Only one eligible: grant it.
  - Both eligible: grant the one not indicated by last. Round-robin; last resets to 0, so data wins the first contention.
  - Grant edge:
    - latch m_addr from the granted address.
    - for data, latch m_wdata and the we bit.
    - set cnt = LAT-1, update last, go to ACC_IF or ACC_D.
- ACC_x:
  - m_en = 1; m_we = latched we (ACC_D only, else 0); cnt decrements each cycle.
  - When cnt = 0:
    - capture m_rdata into if_rdata (ACC_IF) or d_rdata (ACC_D read only).
    - return to IDLE.
    - assert the matching ready for the following cycle only.
- A write never modifies d_rdata. if_rdata and d_rdata change only on completion of their own access.
- m_addr and m_wdata hold their last values outside accesses. Memory ignores them when m_en = 0.
- Reset (rst = 0 at a clock edge, including mid-access):
  - state IDLE, cnt 0, last 0.
  - m_en, m_we, if_ready, d_ready, and busy 0.
  - if_rdata, d_rdata, m_addr, and m_wdata 0.
  - The access in flight is abandoned with no ready pulse. A partial write is permitted; the requester must re-issue.
- Requests arriving during ACC_x wait. No request is dropped while held.
- LAT outside 1..7 is unsupported; no runtime check.

## Timing
- Request high in IDLE cycle t:
  - m_en high in cycles t+1..t+LAT.
  - ready high in cycle t+LAT+1.
  - next grant decision in cycle t+LAT+1 (IDLE).
- Throughput: one access per LAT+1 cycles. Back-to-back alternating fetch/data under constant contention.
- All outputs are registered; no combinational path from inputs to outputs.
- Read data is sampled at the rising edge ending the last m_en cycle.

## Test plan
- Reset: hold rst = 0 for 2 cycles with if_req = d_req = 1. All outputs 0 throughout; after release, the first grant is data (last = 0).
- Single fetch, LAT = 2: if_req at cycle 0, if_addr = 0x004, memory returns 0x2002_0005.
  - m_en high cycles 1–2 with m_addr = 0x004, m_we = 0.
  - if_ready high in cycle 3 only; if_rdata = 0x2002_0005 and held afterwards.
- Data write: d_req = 1, d_we = 1, d_addr = 0x010, d_wdata = 0xDEAD_BEEF.
  - m_we high in the same 2 cycles as m_en.
  - d_ready pulses once; d_rdata unchanged from its prior value.
- Contention: if_req and d_req both held high continuously.
  - Grant order data, fetch, data, fetch.
  - Ready pulses at cycles 3, 6, 9, 12.
  - No requester is served twice in a row.
- Late arrival: d_req rises at cycle 1 while a fetch is in ACC_IF. The data grant occurs in cycle 3, with data m_en in cycles 4–5 and d_ready in cycle 6.
- Reset mid-access: rst = 0 in cycle 2 of a read.
  - No ready pulse; m_en = 0 the next cycle.
  - With the request re-held after release, the access restarts with full LAT latency.
